// File: rtl/branch_resolve_queue_if.sv
// Purpose: bundles the fetch-side enqueue, EX-side resolve and status/statistics
//          signals of branch_resolve_queue.
// Ports (modports):
//   master - fetch/EX side: drives stall, enq_*, res_valid, br_en and br_target,
//            and observes mispredict, redirect_pc, upd_*, full, empty, count,
//            the counters and the sticky error flags.
//   slave  - the queue itself, with the opposite directions.
interface branch_resolve_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             stall;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_pc;
    logic             enq_pred;
    logic [WIDTH-1:0] enq_target;
    logic             res_valid;
    logic             br_en;
    logic [WIDTH-1:0] br_target;

    logic             mispredict;
    logic [WIDTH-1:0] redirect_pc;
    logic             upd_valid;
    logic             upd_taken;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [31:0]      br_count;
    logic [31:0]      mp_count;
    logic             err_ovf;
    logic             err_unf;

    modport master (
        output stall, enq_valid, enq_pc, enq_pred, enq_target,
               res_valid, br_en, br_target,
        input  mispredict, redirect_pc, upd_valid, upd_taken, full, empty,
               count, br_count, mp_count, err_ovf, err_unf
    );

    modport slave (
        input  stall, enq_valid, enq_pc, enq_pred, enq_target,
               res_valid, br_en, br_target,
        output mispredict, redirect_pc, upd_valid, upd_taken, full, empty,
               count, br_count, mp_count, err_ovf, err_unf
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// Purpose: circular queue of in-flight branch predictions. The oldest entry is
//          compared against the EX outcome on resolve; a mismatch produces a
//          registered one-cycle mispredict pulse with the corrected PC and
//          flushes the queue. Every resolve also strobes a predictor update and
//          bumps saturating statistics counters.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, overrides all other activity
//   bus - branch_resolve_queue_if.slave (enqueue, resolve, status, counters)
module branch_resolve_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Returns {mismatch, redirect_pc} for a resolved head entry.
    function automatic logic [WIDTH:0] resolve_f(
        input logic             pred,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] tgt,
        input logic             taken,
        input logic [WIDTH-1:0] act_tgt
    );
        logic [WIDTH:0] r;
        case ({pred, taken})
            2'b10:   r = {1'b1, pc + WIDTH'(32'd4)};   // wraps modulo 2^WIDTH
            2'b01:   r = {1'b1, act_tgt};
            2'b11:   r = {(tgt != act_tgt), act_tgt};
            default: r = {1'b0, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [WIDTH-1:0] tgt_mem_q [DEPTH];
    logic [DEPTH-1:0] pred_mem_q;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mispredict_q, mispredict_d;
    logic [WIDTH-1:0] redirect_q, redirect_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mp_count_q, mp_count_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    logic             empty_s, full_s, enq_s, res_try_s, res_s, mm_s, push_s, pop_s;
    logic [WIDTH:0]   cmp_s;

    assign empty_s   = (count_q == CNT_W'(0));
    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign enq_s     = bus.enq_valid & ~bus.stall;
    assign res_try_s = bus.res_valid & ~bus.stall;
    assign res_s     = res_try_s & ~empty_s;
    assign cmp_s     = resolve_f(pred_mem_q[head_q], pc_mem_q[head_q], tgt_mem_q[head_q],
                                 bus.br_en, bus.br_target);
    assign mm_s      = res_s & cmp_s[WIDTH];

    // Next-state: pointer/count movement, flush, pulses, counters and sticky errors.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        mispredict_d = mm_s;
        upd_valid_d  = res_s;
        upd_taken_d  = upd_taken_q;
        redirect_d   = redirect_q;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        err_ovf_d    = err_ovf_q | (enq_s & full_s & ~res_s);
        err_unf_d    = err_unf_q | (res_try_s & empty_s);

        if (mm_s) begin
            // Flush: everything younger is wrong-path, including a same-cycle enqueue.
            head_d  = tail_q;
            count_d = CNT_W'(0);
        end else begin
            // A correct resolve frees the head slot, so push is legal even when full.
            pop_s   = res_s;
            push_s  = enq_s & (~full_s | res_s);
            head_d  = head_q + PTR_W'(pop_s);
            tail_d  = tail_q + PTR_W'(push_s);
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        if (res_s) begin
            upd_taken_d = bus.br_en;
            if (br_count_q != 32'hFFFF_FFFF) begin
                br_count_d = br_count_q + 32'd1;
            end else begin
                br_count_d = br_count_q;
            end
        end else begin
            upd_taken_d = upd_taken_q;
        end

        if (mm_s) begin
            redirect_d = cmp_s[WIDTH-1:0];
            if (mp_count_q != 32'hFFFF_FFFF) begin
                mp_count_d = mp_count_q + 32'd1;
            end else begin
                mp_count_d = mp_count_q;
            end
        end else begin
            redirect_d = redirect_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            br_count_q   <= 32'd0;
            mp_count_q   <= 32'd0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            upd_valid_q  <= upd_valid_d;
            upd_taken_q  <= upd_taken_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
            err_ovf_q    <= err_ovf_d;
            err_unf_q    <= err_unf_d;
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            pc_mem_q[tail_q]   <= bus.enq_pc;
            tgt_mem_q[tail_q]  <= bus.enq_target;
            pred_mem_q[tail_q] <= bus.enq_pred;
        end
    end

    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.count       = count_q;
    assign bus.br_count    = br_count_q;
    assign bus.mp_count    = mp_count_q;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.err_unf     = err_unf_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed testbench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    branch_resolve_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();

    branch_resolve_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are captured at this edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall      = 1'b0;
        bus.enq_valid  = 1'b0;
        bus.enq_pc     = 32'd0;
        bus.enq_pred   = 1'b0;
        bus.enq_target = 32'd0;
        bus.res_valid  = 1'b0;
        bus.br_en      = 1'b0;
        bus.br_target  = 32'd0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        bus.enq_valid  = 1'b1;
        bus.enq_pc     = pc;
        bus.enq_pred   = pred;
        bus.enq_target = tgt;
    endtask

    task automatic res(input logic taken, input logic [31:0] tgt);
        bus.res_valid = 1'b1;
        bus.br_en     = taken;
        bus.br_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_mp", 32'(bus.mispredict), 32'd0);
        check("rst_upd", 32'(bus.upd_valid), 32'd0);
        check("rst_redir", bus.redirect_pc, 32'd0);
        check("rst_brc", bus.br_count, 32'd0);
        check("rst_errs", 32'({bus.err_ovf, bus.err_unf}), 32'd0);

        // 1) predicted not-taken, actually taken
        enq(32'h100, 1'b0, 32'h0);
        step();
        idle();
        check("t1_count1", 32'(bus.count), 32'd1);
        res(1'b1, 32'h200);
        step();
        idle();
        check("t1_mp", 32'(bus.mispredict), 32'd1);
        check("t1_redir", bus.redirect_pc, 32'h200);
        check("t1_updv", 32'(bus.upd_valid), 32'd1);
        check("t1_updt", 32'(bus.upd_taken), 32'd1);
        check("t1_count0", 32'(bus.count), 32'd0);
        check("t1_mpc", bus.mp_count, 32'd1);
        step();
        check("t1_mp_drop", 32'(bus.mispredict), 32'd0);
        check("t1_redir_hold", bus.redirect_pc, 32'h200);

        // 2) correct taken prediction with matching target
        do_reset();
        enq(32'h40, 1'b1, 32'h80);
        step();
        idle();
        res(1'b1, 32'h80);
        step();
        idle();
        check("t2_updv", 32'(bus.upd_valid), 32'd1);
        check("t2_mp", 32'(bus.mispredict), 32'd0);
        check("t2_brc", bus.br_count, 32'd1);
        check("t2_mpc", bus.mp_count, 32'd0);

        // 3) fill, then simultaneous enq + correct res while full, then overflow
        for (int i = 0; i < 4; i++) begin
            enq(32'h10 + 32'(i) * 32'd4, 1'b0, 32'h0);
            step();
        end
        idle();
        check("t3_full", 32'(bus.full), 32'd1);
        check("t3_count4", 32'(bus.count), 32'd4);
        enq(32'h20, 1'b1, 32'h99);
        res(1'b0, 32'h0);
        step();
        idle();
        check("t3_cnt_keep", 32'(bus.count), 32'd4);
        check("t3_full_keep", 32'(bus.full), 32'd1);
        check("t3_ovf0", 32'(bus.err_ovf), 32'd0);
        check("t3_brc", bus.br_count, 32'd2);
        enq(32'h30, 1'b1, 32'h77);
        step();
        idle();
        check("t3_ovf1", 32'(bus.err_ovf), 32'd1);
        check("t3_cnt_drop", 32'(bus.count), 32'd4);
        // drain: three correct not-taken, then the tail entry (pc 0x20, pred taken) resolves not-taken
        for (int i = 0; i < 3; i++) begin
            res(1'b0, 32'h0);
            step();
        end
        res(1'b0, 32'h0);
        step();
        idle();
        check("t3_tail_mp", 32'(bus.mispredict), 32'd1);
        check("t3_tail_redir", bus.redirect_pc, 32'h24);
        check("t3_empty", 32'(bus.empty), 32'd1);
        check("t3_brc6", bus.br_count, 32'd6);

        // 4) taken prediction at top of address space resolves not-taken: pc+4 wraps
        enq(32'hFFFF_FFFC, 1'b1, 32'h1000);
        step();
        enq(32'h50, 1'b0, 32'h0);
        step();
        enq(32'h54, 1'b0, 32'h0);
        step();
        idle();
        check("t4_count3", 32'(bus.count), 32'd3);
        res(1'b0, 32'h0);
        enq(32'h500, 1'b0, 32'h0);
        step();
        idle();
        check("t4_mp", 32'(bus.mispredict), 32'd1);
        check("t4_redir", bus.redirect_pc, 32'h0);
        check("t4_count0", 32'(bus.count), 32'd0);
        check("t4_mpc", bus.mp_count, 32'd2);
        step();
        check("t4_enq_dropped", 32'(bus.count), 32'd0);

        // 5) stall freezes everything
        enq(32'h60, 1'b0, 32'h0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            enq(32'h70, 1'b0, 32'h0);
            res(1'b1, 32'h300);
            step();
            check("t5_cnt", 32'(bus.count), 32'd1);
            check("t5_pulses", 32'({bus.mispredict, bus.upd_valid}), 32'd0);
            check("t5_brc", bus.br_count, 32'd7);
        end
        idle();
        check("t5_errs", 32'({bus.err_ovf, bus.err_unf}), 32'b10);
        res(1'b0, 32'h0);
        step();
        idle();
        check("t5_res_ok", bus.br_count, 32'd8);
        res(1'b1, 32'h0);
        step();
        idle();
        check("t5_unf", 32'(bus.err_unf), 32'd1);
        check("t5_unf_noupd", 32'(bus.upd_valid), 32'd0);
        check("t5_unf_brc", bus.br_count, 32'd8);

        // 6) reset mid-sequence with two entries queued
        enq(32'h80, 1'b1, 32'h90);
        step();
        enq(32'h84, 1'b0, 32'h0);
        step();
        idle();
        check("t6_count2", 32'(bus.count), 32'd2);
        rst = 1'b1;
        res(1'b0, 32'h0);
        step();
        rst = 1'b0;
        idle();
        check("t6_count", 32'(bus.count), 32'd0);
        check("t6_empty", 32'(bus.empty), 32'd1);
        check("t6_ctrs", bus.br_count | bus.mp_count, 32'd0);
        check("t6_errs", 32'({bus.err_ovf, bus.err_unf}), 32'd0);
        check("t6_pulses", 32'({bus.mispredict, bus.upd_valid, bus.upd_taken}), 32'd0);
        check("t6_redir", bus.redirect_pc, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
